// File: rtl/wb_arbiter_if.sv
// Bundle of writeback-arbiter signals: pipeline/long-latency inputs, issue tracking,
// and the register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            p_valid;
    logic [4:0]      p_rd;
    logic [XLEN-1:0] p_data;
    logic            s_valid;
    logic            s_ready;
    logic [4:0]      s_rd;
    logic [XLEN-1:0] s_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [31:0]     busy;
    logic            p_stall;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;

    modport slave (
        input  p_valid, p_rd, p_data,
        input  s_valid, s_rd, s_data,
        input  iss_valid, iss_rd,
        output s_ready, busy, p_stall,
        output we, rd, rd_data
    );

    modport master (
        output p_valid, p_rd, p_data,
        output s_valid, s_rd, s_data,
        output iss_valid, iss_rd,
        input  s_ready, busy, p_stall,
        input  we, rd, rd_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Merges single-cycle pipeline writebacks and FIFO-buffered long-latency results onto
// one register-file write port; tracks outstanding long-latency destinations.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int          IDX_W      = $clog2(FIFO_DEPTH);
    localparam int          PTR_W      = IDX_W + 1;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [4:0]      fifo_rd_d   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_d [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       starve_q, starve_d;
    logic             p_stall_q, p_stall_d;
    logic [31:0]      busy_q, busy_d;
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             p_win;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_data;

    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Ready is from registered full only, so a same-cycle pop never frees a slot early.
    assign bus.s_ready = !full && !rst;

    assign push      = bus.s_valid && bus.s_ready;
    assign p_win     = bus.p_valid && (bus.p_rd != 5'd0);
    assign pop       = !p_win && !empty;
    assign head_rd   = fifo_rd_q[rd_ptr_q[IDX_W-1:0]];
    assign head_data = fifo_data_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        we_d        = 1'b0;
        rd_d        = rd_q;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        starve_d    = starve_q;

        if (push) begin
            fifo_rd_d[wr_ptr_q[IDX_W-1:0]]   = bus.s_rd;
            fifo_data_d[wr_ptr_q[IDX_W-1:0]] = bus.s_data;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (p_win) begin
            we_d      = 1'b1;
            rd_d      = bus.p_rd;
            rd_data_d = bus.p_data;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head_rd != 5'd0) begin
                we_d      = 1'b1;
                rd_d      = head_rd;
                rd_data_d = head_data;
            end
        end

        // Clear before set so an issue to the register being retired keeps it busy.
        if (pop && (head_rd != 5'd0))
            busy_d[head_rd] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != 5'd0))
            busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;

        if (empty || pop)
            starve_d = 4'd0;
        else if (starve_q < STARVE_LIM)
            starve_d = starve_q + 4'd1;

        p_stall_d = (starve_d == STARVE_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= 4'd0;
            p_stall_q <= 1'b0;
            busy_q    <= 32'd0;
            we_q      <= 1'b0;
            rd_q      <= 5'd0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            starve_q  <= starve_d;
            p_stall_q <= p_stall_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign bus.busy    = busy_q;
    assign bus.p_stall = p_stall_q;
    assign bus.we      = we_q;
    assign bus.rd      = rd_q;
    assign bus.rd_data = rd_data_q;
endmodule
